// File: rtl/poly_pkg.sv
// Shared constants for the polynomial slot store: command opcodes and the
// bulk-engine state enumeration, used by the sequencer, the store and the bench.
package poly_pkg;

    localparam logic OP_CLEAR = 1'b0;
    localparam logic OP_COPY  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_COPY      = 3'd2,
        ST_COPY_TAIL = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

endpackage

// File: rtl/poly_bank_ram.sv
// Generic true dual-port, read-first RAM. Each port reads the pre-edge content
// of its address into a registered output; writes land after the edge.
// Only the output registers are reset, which keeps the array BRAM-inferable.
module poly_bank_ram #(
    parameter int DW    = 12,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_a,
    input  logic [$clog2(DEPTH)-1:0] addr_a,
    input  logic [DW-1:0]            din_a,
    output logic [DW-1:0]            dout_a,
    input  logic                     we_b,
    input  logic [$clog2(DEPTH)-1:0] addr_b,
    input  logic [DW-1:0]            din_b,
    output logic [DW-1:0]            dout_b
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] q_a_r;
    logic [DW-1:0] q_b_r;

    // Array writes from both ports; the two addresses never collide in legal use.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem_r[addr_a] <= din_a;
        end
        if (we_b) begin
            mem_r[addr_b] <= din_b;
        end
    end

    // Registered read-first outputs, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_a_r <= {DW{1'b0}};
            q_b_r <= {DW{1'b0}};
        end else begin
            q_a_r <= mem_r[addr_a];
            q_b_r <= mem_r[addr_b];
        end
    end

    assign dout_a = q_a_r;
    assign dout_b = q_b_r;

endmodule

// File: rtl/poly_bank.sv
// Multi-slot polynomial coefficient store. Ports A/B give the datapath
// per-coefficient access; a bulk engine clears or copies whole slots on command
// and owns both RAM ports while busy.
module poly_bank
    import poly_pkg::*;
#(
    parameter int W     = 12,
    parameter int N     = 256,
    parameter int NSLOT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_a,
    input  logic [$clog2(NSLOT)-1:0] slot_a,
    input  logic [$clog2(N)-1:0]     addr_a,
    input  logic [W-1:0]             din_a,
    output logic [W-1:0]             dout_a,
    input  logic                     we_b,
    input  logic [$clog2(NSLOT)-1:0] slot_b,
    input  logic [$clog2(N)-1:0]     addr_b,
    input  logic [W-1:0]             din_b,
    output logic [W-1:0]             dout_b,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_op,
    input  logic [$clog2(NSLOT)-1:0] cmd_src,
    input  logic [$clog2(NSLOT)-1:0] cmd_dst,
    output logic                     busy,
    output logic                     done
);

    localparam int AW  = $clog2(N);
    localparam int SW  = $clog2(NSLOT);
    localparam int RAW = AW + SW;

    localparam logic [AW-1:0] K_ONE       = AW'(1);
    localparam logic [AW-1:0] K_HALF_LAST = AW'(N / 2 - 1);
    localparam logic [AW-1:0] K_LAST      = AW'(N - 1);

    state_e          state_r;
    state_e          state_s;
    logic [AW-1:0]   k_r;
    logic [AW-1:0]   k_s;
    logic            accept_s;
    logic [SW-1:0]   src_r;
    logic [SW-1:0]   dst_r;
    logic            cmd_ready_r;
    logic            busy_r;
    logic            done_r;

    logic            ram_we_a_s;
    logic [RAW-1:0]  ram_addr_a_s;
    logic [W-1:0]    ram_din_a_s;
    logic [W-1:0]    ram_q_a_s;
    logic            ram_we_b_s;
    logic [RAW-1:0]  ram_addr_b_s;
    logic [W-1:0]    ram_din_b_s;
    logic [W-1:0]    ram_q_b_s;

    // Next-state and counter logic of the bulk engine.
    always_comb begin
        state_s  = state_r;
        k_s      = k_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    accept_s = 1'b1;
                    k_s      = {AW{1'b0}};
                    if (cmd_op == OP_COPY) begin
                        state_s = ST_COPY;
                    end else begin
                        state_s = ST_CLEAR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (k_r == K_HALF_LAST) begin
                    state_s = ST_DONE;
                    k_s     = {AW{1'b0}};
                end else begin
                    state_s = ST_CLEAR;
                    k_s     = k_r + K_ONE;
                end
            end
            ST_COPY: begin
                if (k_r == K_LAST) begin
                    state_s = ST_COPY_TAIL;
                    k_s     = {AW{1'b0}};
                end else begin
                    state_s = ST_COPY;
                    k_s     = k_r + K_ONE;
                end
            end
            ST_COPY_TAIL: begin
                state_s = ST_DONE;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                k_s     = {AW{1'b0}};
            end
        endcase
    end

    // State and coefficient counter registers; reset aborts any command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            k_r     <= {AW{1'b0}};
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
        end
    end

    // Slot operands captured when a command is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_r <= {SW{1'b0}};
            dst_r <= {SW{1'b0}};
        end else if (accept_s) begin
            src_r <= cmd_src;
            dst_r <= cmd_dst;
        end
    end

    // Status outputs registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cmd_ready_r <= (state_s == ST_IDLE);
            busy_r      <= (state_s == ST_CLEAR) || (state_s == ST_COPY) ||
                           (state_s == ST_COPY_TAIL);
            done_r      <= (state_s == ST_DONE);
        end
    end

    // Port mux: the engine drives both RAM ports while busy, users otherwise.
    // COPY is a two-stage pipe: A reads src[k], B writes that word to dst[k-1].
    always_comb begin
        ram_we_a_s   = we_a;
        ram_addr_a_s = {slot_a, addr_a};
        ram_din_a_s  = din_a;
        ram_we_b_s   = we_b;
        ram_addr_b_s = {slot_b, addr_b};
        ram_din_b_s  = din_b;
        case (state_r)
            ST_CLEAR: begin
                ram_we_a_s   = 1'b1;
                ram_addr_a_s = {dst_r, k_r[AW-2:0], 1'b0};
                ram_din_a_s  = {W{1'b0}};
                ram_we_b_s   = 1'b1;
                ram_addr_b_s = {dst_r, k_r[AW-2:0], 1'b1};
                ram_din_b_s  = {W{1'b0}};
            end
            ST_COPY: begin
                ram_we_a_s   = 1'b0;
                ram_addr_a_s = {src_r, k_r};
                ram_din_a_s  = {W{1'b0}};
                ram_we_b_s   = (k_r != {AW{1'b0}});
                ram_addr_b_s = {dst_r, k_r - K_ONE};
                ram_din_b_s  = ram_q_a_s;
            end
            ST_COPY_TAIL: begin
                ram_we_a_s   = 1'b0;
                ram_addr_a_s = {src_r, k_r};
                ram_din_a_s  = {W{1'b0}};
                ram_we_b_s   = 1'b1;
                ram_addr_b_s = {dst_r, K_LAST};
                ram_din_b_s  = ram_q_a_s;
            end
            default: begin
                ram_we_a_s   = we_a;
                ram_addr_a_s = {slot_a, addr_a};
                ram_din_a_s  = din_a;
                ram_we_b_s   = we_b;
                ram_addr_b_s = {slot_b, addr_b};
                ram_din_b_s  = din_b;
            end
        endcase
    end

    poly_bank_ram #(
        .DW    (W),
        .DEPTH (NSLOT * N)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_a   (ram_we_a_s),
        .addr_a (ram_addr_a_s),
        .din_a  (ram_din_a_s),
        .dout_a (ram_q_a_s),
        .we_b   (ram_we_b_s),
        .addr_b (ram_addr_b_s),
        .din_b  (ram_din_b_s),
        .dout_b (ram_q_b_s)
    );

    assign dout_a    = ram_q_a_s;
    assign dout_b    = ram_q_b_s;
    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_poly_bank.sv
// Scoreboard bench for poly_bank: a slot-array reference model predicts every
// read and every done pulse; a monitor compares them as the DUT presents them.
module tb_poly_bank;
    import poly_pkg::*;

    localparam int W     = 12;
    localparam int N     = 256;
    localparam int NSLOT = 4;
    localparam int AW    = $clog2(N);
    localparam int SW    = $clog2(NSLOT);
    localparam int LIMIT = 2000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we_a, we_b;
    logic [SW-1:0] slot_a, slot_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [W-1:0]  din_a, din_b;
    logic [W-1:0]  dout_a, dout_b;
    logic          cmd_valid, cmd_ready, cmd_op, busy, done;
    logic [SW-1:0] cmd_src, cmd_dst;

    poly_bank #(.W(W), .N(N), .NSLOT(NSLOT)) dut (
        .clk(clk), .rst_n(rst_n),
        .we_a(we_a), .slot_a(slot_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
        .we_b(we_b), .slot_b(slot_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   ref_mem [NSLOT][N];
    int   qa[$];
    int   qb[$];
    int   done_q[$];
    logic chk_a_pend = 1'b0, chk_b_pend = 1'b0;
    logic chk_a_vld  = 1'b0, chk_b_vld  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter (value after the latest rising edge) and read-valid pipe.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        chk_a_vld <= chk_a_pend;
        chk_b_vld <= chk_b_pend;
    end

    // Monitor: pops expected read data and done pulses on the falling edge.
    always @(negedge clk) begin
        logic exp_d;
        if (chk_a_vld && qa.size() > 0) chk("rd_a", int'(dout_a), qa.pop_front());
        if (chk_b_vld && qb.size() > 0) chk("rd_b", int'(dout_b), qb.pop_front());
        exp_d = (done_q.size() > 0) && (done_q[0] == cyc);
        if (done || exp_d) begin
            chk("done_pulse", int'(done), int'(exp_d));
            if (exp_d) void'(done_q.pop_front());
            if (done) begin
                chk("done_ready_low", int'(cmd_ready), 0);
                chk("done_busy_low", int'(busy), 0);
            end
        end
    end

    function automatic int pattern(input int kind, input int i);
        if (kind == 0) return i + 1;
        else if (kind == 1) return (3 * i) % 3329;
        else return int'($urandom_range(0, 4095));
    endfunction

    // One user cycle on both ports; reads predicted from the model before writes.
    task automatic port_op(input logic wa, input int sa, input int aa, input int da, input logic ra,
                           input logic wb, input int sb, input int ab, input int db, input logic rb);
        @(negedge clk);
        we_a = wa; slot_a = SW'(sa); addr_a = AW'(aa); din_a = W'(da);
        we_b = wb; slot_b = SW'(sb); addr_b = AW'(ab); din_b = W'(db);
        if (ra) qa.push_back(ref_mem[sa][aa]);
        if (rb) qb.push_back(ref_mem[sb][ab]);
        if (wa) ref_mem[sa][aa] = da % 4096;
        if (wb) ref_mem[sb][ab] = db % 4096;
        chk_a_pend = ra;
        chk_b_pend = rb;
        @(posedge clk);
        #1;
        we_a = 1'b0; we_b = 1'b0;
        chk_a_pend = 1'b0; chk_b_pend = 1'b0;
    endtask

    task automatic fill_slot(input int s, input int kind);
        for (int i = 0; i < N; i += 2)
            port_op(1'b1, s, i, pattern(kind, i), 1'b0, 1'b1, s, i + 1, pattern(kind, i + 1), 1'b0);
    endtask

    task automatic check_slot(input int s);
        for (int i = 0; i < N; i += 2)
            port_op(1'b0, s, i, 0, 1'b1, 1'b0, s, i + 1, 0, 1'b1);
    endtask

    // Raise a command, wait (bounded) for acceptance; cmd_valid is left high.
    task automatic issue_cmd(input logic op, input int src, input int dst, output int t_acc);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_src = SW'(src); cmd_dst = SW'(dst);
        while (!cmd_ready && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        t_acc = cyc;
        if (t >= LIMIT) begin
            chk("cmd_accept_timeout", t, 0);
        end else begin
            @(posedge clk);
            #1;
            t_acc = cyc;
            chk("busy_after_accept", int'(busy), 1);
            chk("ready_after_accept", int'(cmd_ready), 0);
            if (op == OP_COPY) begin
                done_q.push_back(t_acc + N + 1);
                ref_mem[dst] = ref_mem[src];
            end else begin
                done_q.push_back(t_acc + N / 2);
                for (int i = 0; i < N; i++) ref_mem[dst][i] = 0;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) chk("idle_timeout", t, 0);
    endtask

    task automatic random_ops(input int count);
        for (int n = 0; n < count; n++) begin
            int sa = int'($urandom_range(0, NSLOT - 1));
            int aa = int'($urandom_range(0, N - 1));
            int sb = int'($urandom_range(0, NSLOT - 1));
            int ab = ($urandom_range(0, 3) == 0) ? aa : int'($urandom_range(0, N - 1));
            logic wa = 1'($urandom_range(0, 1));
            logic wb = 1'($urandom_range(0, 1));
            if (wa && wb && sa == sb && aa == ab) wb = 1'b0;
            port_op(wa, sa, aa, int'($urandom_range(0, 4095)), 1'b1,
                    wb, sb, ab, int'($urandom_range(0, 4095)), 1'b1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int t1, t2;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_CLEAR; cmd_src = '0; cmd_dst = '0;
        we_a = 1'b0; slot_a = '0; addr_a = '0; din_a = '0;
        we_b = 1'b0; slot_b = '0; addr_b = '0; din_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dout_a", int'(dout_a), 0);
        chk("rst_dout_b", int'(dout_b), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < NSLOT; s++) fill_slot(s, 2);

        // Read-first: B sees the old value while A overwrites, then the new one.
        port_op(1'b1, 1, 5, 'hABC, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        port_op(1'b1, 1, 5, 'h123, 1'b0, 1'b0, 1, 5, 0, 1'b1);
        port_op(1'b0, 0, 0, 0, 1'b0, 1'b0, 1, 5, 0, 1'b1);

        random_ops(300);

        // CLEAR slot 2, then every slot is read back.
        fill_slot(2, 0);
        issue_cmd(OP_CLEAR, 0, 2, t1);
        cmd_valid = 1'b0;
        wait_idle();
        for (int s = 0; s < NSLOT; s++) check_slot(s);

        // COPY 0 -> 3.
        fill_slot(0, 1);
        issue_cmd(OP_COPY, 0, 3, t1);
        cmd_valid = 1'b0;
        wait_idle();
        check_slot(3);
        check_slot(0);

        // User writes during a COPY have no effect.
        issue_cmd(OP_COPY, 1, 3, t1);
        cmd_valid = 1'b0;
        repeat (100) @(negedge clk);
        we_a = 1'b1; slot_a = SW'(3); addr_a = AW'(7);   din_a = 12'hFFF;
        we_b = 1'b1; slot_b = SW'(3); addr_b = AW'(200); din_b = 12'h555;
        @(posedge clk);
        #1;
        we_a = 1'b0; we_b = 1'b0;
        wait_idle();
        check_slot(3);

        // COPY onto itself.
        issue_cmd(OP_COPY, 2, 2, t1);
        cmd_valid = 1'b0;
        wait_idle();
        check_slot(2);

        // Reset abort at k = 40 of a CLEAR: no done, idle outputs after the edge.
        issue_cmd(OP_CLEAR, 0, 0, t1);
        cmd_valid = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        done_q.delete();
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_dout_a", int'(dout_a), 0);
        chk("abort_dout_b", int'(dout_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        fill_slot(0, 0);
        fill_slot(2, 2);
        issue_cmd(OP_COPY, 2, 0, t1);
        cmd_valid = 1'b0;
        wait_idle();
        check_slot(0);

        // Back-to-back with cmd_valid held high across both commands.
        fill_slot(3, 2);
        issue_cmd(OP_CLEAR, 0, 1, t1);
        issue_cmd(OP_COPY, 3, 1, t2);
        cmd_valid = 1'b0;
        chk("b2b_second_accept", t2, t1 + N / 2 + 2);
        wait_idle();
        check_slot(1);
        check_slot(3);

        repeat (3) @(negedge clk);
        chk("done_queue_drained", done_q.size(), 0);
        chk("read_queue_drained", qa.size() + qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
